// File: rtl/prbs5_pkg.sv
// prbs5_pkg: shared definitions for the PRBS5 checker slice.
//   state_t : checker FSM state encoding (HUNT / SYNC / LOCKED)
//   SEED    : generator seed word, also the period marker
//   PERIOD  : sequence length of the maximal x^5+x^2+1 LFSR
//   FB_MASK : bit positions XORed with the feedback bit (the x^2 tap)
//   PER_W   : width of the period counter
package prbs5_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] SEED    = 5'b11111;
  localparam int         PERIOD  = 31;
  // Rotating left moves bit 4 into bit 0; the x^2 tap also folds it into bit 2.
  localparam logic [4:0] FB_MASK = 5'b00100;
  // One bit wider than PERIOD needs, so an overlong gap saturates instead of
  // wrapping back onto a legal-looking count.
  localparam int         PER_W   = 6;

endpackage

// File: rtl/prbs5_step.sv
// prbs5_step: combinational one-step predictor of the lfsr5b state word.
//   i_p   [4:0] : current state word
//   o_nxt [4:0] : state word the generator produces next
//                 {p[3], p[2], p[4]^p[1], p[0], p[4]}
module prbs5_step
  import prbs5_pkg::*;
(
  input  logic [4:0] i_p,
  output logic [4:0] o_nxt
);

  assign o_nxt = {i_p[3:0], i_p[4]} ^ (FB_MASK & {5{i_p[4]}});

endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: lock-and-monitor checker for the parallel lfsr5b state word.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : q_in carries a valid sample this cycle; there is no
//                     backpressure, every cycle with en=1 is consumed
//   q_in [4:0]      : generator state word
//   clr             : synchronous clear of err_cnt, zero_err, period_err
//   locked          : FSM is in LOCKED
//   err_pulse       : one-cycle flag, mismatch seen while LOCKED
//   err_cnt         : saturating count of mismatches seen while LOCKED
//   zero_err        : sticky, an all-zero word was accepted
//   period_err      : sticky, a seed-to-seed distance other than PERIOD
//   dbg_state [1:0] : current FSM state for debug
// All outputs are registered and change on the edge that accepts a sample.
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       q_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             zero_err,
  output logic             period_err,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t             r_state;
  logic [3:0]         r_run;
  logic [3:0]         r_miss;
  logic               r_have_prev;
  logic [4:0]         r_prev_q;
  logic [PER_W-1:0]   r_per_cnt;
  logic               r_per_valid;
  logic               r_locked;
  logic               r_err_pulse;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_zero_err;
  logic               r_period_err;

  logic [4:0]         w_pred;
  logic               w_cmp;
  logic               w_match;
  logic               w_in_lock;
  state_t             w_state_nxt;
  logic [3:0]         w_run_nxt;
  logic [3:0]         w_miss_nxt;

  prbs5_step u_step (
    .i_p   (r_prev_q),
    .o_nxt (w_pred)
  );

  // The very first accepted sample only primes r_prev_q.
  assign w_cmp     = en && r_have_prev;
  assign w_match   = (q_in == w_pred) && (q_in != 5'd0);
  assign w_in_lock = (r_state == ST_LOCKED);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    if (w_cmp) begin
      case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            if (LOCK_N == 4'd1) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_state_nxt = ST_SYNC;
              w_run_nxt   = 4'd1;
            end
          end
        end
        ST_SYNC: begin
          if (w_match) begin
            if (r_run + 4'd1 == LOCK_N) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_run_nxt   = r_run + 4'd1;
            end
          end else begin
            w_state_nxt = ST_HUNT;
            w_run_nxt   = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_miss_nxt = 4'd0;
          end else if (r_miss + 4'd1 == LOSS_N) begin
            w_state_nxt = ST_HUNT;
            w_miss_nxt  = 4'd0;
            w_run_nxt   = 4'd0;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = 4'd0;
          w_miss_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_run        <= 4'd0;
      r_miss       <= 4'd0;
      r_have_prev  <= 1'b0;
      r_prev_q     <= 5'd0;
      r_per_cnt    <= '0;
      r_per_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
      r_zero_err   <= 1'b0;
      r_period_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_miss      <= w_miss_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= 1'b0;
      if (en) begin
        // Load on every accepted word so a corrupted stream re-aligns itself.
        r_prev_q    <= q_in;
        r_have_prev <= 1'b1;
        if (q_in == 5'd0) begin
          r_zero_err <= 1'b1;
        end
        if (w_cmp && w_in_lock && !w_match) begin
          r_err_pulse <= 1'b1;
          if (r_err_cnt != {CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
        // r_per_cnt holds samples since the last seed; the seed-to-seed
        // distance is therefore r_per_cnt + 1.
        if (w_in_lock) begin
          if (q_in == SEED) begin
            if (r_per_valid && (r_per_cnt != PER_W'(PERIOD - 1))) begin
              r_period_err <= 1'b1;
            end
            r_per_cnt   <= '0;
            r_per_valid <= 1'b1;
          end else if (r_per_cnt != {PER_W{1'b1}}) begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
          end
        end
        // Invalidation wins over the arm above when this sample drops lock.
        if (w_state_nxt != ST_LOCKED) begin
          r_per_valid <= 1'b0;
        end
      end
      // Clear is last so it overrides a same-cycle set or increment.
      if (clr) begin
        r_err_cnt    <= '0;
        r_zero_err   <= 1'b0;
        r_period_err <= 1'b0;
      end
    end
  end

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;
  assign zero_err   = r_zero_err;
  assign period_err = r_period_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: directed bench for prbs5_checker with a behavioural model.
module tb_prbs5_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int CNT_W    = 8;
  localparam logic [4:0] SEED_W = 5'b11111;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [4:0]       q_in = 5'd0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic             zero_err;
  logic             period_err;
  logic [1:0]       dbg_state;

  prbs5_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .q_in       (q_in),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .zero_err   (zero_err),
    .period_err (period_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t act=running req=finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference sequence table ----------------
  logic [4:0] seq [0:30];
  int         idx_of [0:31];
  int         pos;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Galois form of x^5+x^2+1: shift left, fold the dropped bit back in.
  function automatic logic [4:0] poly_step(input logic [4:0] p);
    logic [4:0] s;
    s = {p[3:0], 1'b0};
    if (p[4]) s = s ^ 5'b00101;
    return s;
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic [11:0] exp_q[$];
  bit          m_have;
  logic [4:0]  m_prev;
  bit          m_locked;
  int          m_good, m_bad, m_errs;
  bit          m_zero, m_per;
  int          m_acc, m_last_seed;
  bit          m_pulse, m_match;

  task automatic model_reset();
    m_have = 0; m_prev = 5'd0; m_locked = 0;
    m_good = 0; m_bad = 0; m_errs = 0;
    m_zero = 0; m_per = 0;
    m_acc = 0; m_last_seed = -1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      m_pulse = 0;
      if (en) begin
        m_acc++;
        if (q_in == 5'd0) m_zero = 1;
        if (m_have) begin
          m_match = (m_prev != 5'd0) && (q_in != 5'd0) &&
                    (q_in == seq[(idx_of[m_prev] + 1) % 31]);
          if (m_locked) begin
            if (q_in == SEED_W) begin
              if (m_last_seed >= 0 && (m_acc - m_last_seed) != 31) m_per = 1;
              m_last_seed = m_acc;
            end
            if (m_match) begin
              m_bad = 0;
            end else begin
              m_pulse = 1;
              if (m_errs < 255) m_errs++;
              m_bad++;
              if (m_bad == LOSS_CNT) begin
                m_locked = 0; m_bad = 0; m_good = 0; m_last_seed = -1;
              end
            end
          end else if (m_match) begin
            m_good++;
            if (m_good == LOCK_CNT) begin
              m_locked = 1; m_good = 0; m_last_seed = -1;
            end
          end else begin
            m_good = 0;
          end
        end
        m_have = 1;
        m_prev = q_in;
      end
      if (clr) begin
        m_errs = 0; m_zero = 0; m_per = 0;
      end
      exp_q.push_back({m_locked, m_pulse, 8'(m_errs), m_zero, m_per});
    end
  end

  logic [11:0] cmp_exp, cmp_act;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_act = {locked, err_pulse, err_cnt, zero_err, period_err};
      n_checks++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t act=%h exp=%h (locked,pulse,cnt,zero,per)",
                 $time, cmp_act, cmp_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit e, input logic [4:0] q, input bit c);
    @(negedge clk);
    en = e; q_in = q; clr = c;
  endtask

  task automatic send_good();
    drive(1'b1, seq[pos % 31], 1'b0);
    pos++;
  endtask

  // Step past slots holding the seed or the word about to be injected.
  task automatic avoid(input logic [4:0] w);
    while (seq[pos % 31] == SEED_W || seq[pos % 31] == w) send_good();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    seq[0] = SEED_W;
    for (int i = 1; i < 31; i++) seq[i] = poly_step(seq[i-1]);
    for (int i = 0; i < 32; i++) idx_of[i] = 0;
    for (int i = 0; i < 31; i++) idx_of[seq[i]] = i;
    pos = 0;

    // Reset state, observed before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_zero_err", int'(zero_err), 0);
    chk("rst_period_err", int'(period_err), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Lock on the 5th sample of a clean stream.
    repeat (4) send_good();
    settle();
    chk("lock_before_5th", int'(locked), 0);
    send_good();
    settle();
    chk("lock_at_5th", int'(locked), 1);
    repeat (95) send_good();
    settle();
    chk("clean100_locked", int'(locked), 1);
    chk("clean100_err_cnt", int'(err_cnt), 0);
    chk("clean100_period_err", int'(period_err), 0);

    // Single corrupted word: it mispredicts, and so does the word after it
    // (predicted from 10101 = 01111, which is never the true successor here).
    avoid(5'b10101);
    drive(1'b1, 5'b10101, 1'b0); pos++;
    settle();
    chk("bad1_pulse", int'(err_pulse), 1);
    chk("bad1_err_cnt", int'(err_cnt), 1);
    chk("bad1_locked", int'(locked), 1);
    send_good();
    settle();
    chk("bad1_next_err_cnt", int'(err_cnt), 2);
    send_good();
    settle();
    chk("bad1_resync_pulse", int'(err_pulse), 0);
    repeat (5) send_good();
    settle();
    chk("bad1_after_err_cnt", int'(err_cnt), 2);
    chk("bad1_after_locked", int'(locked), 1);

    // Three bad words drop lock; relock within five correct words.
    avoid(5'b01010);
    drive(1'b1, 5'b01010, 1'b0); pos++;
    settle();
    chk("loss_1_locked", int'(locked), 1);
    drive(1'b1, 5'b01010, 1'b0); pos++;
    settle();
    chk("loss_2_locked", int'(locked), 1);
    drive(1'b1, 5'b01010, 1'b0); pos++;
    settle();
    chk("loss_3_locked", int'(locked), 0);
    chk("loss_3_err_cnt", int'(err_cnt), 5);
    repeat (3) send_good();
    settle();
    chk("relock_3_locked", int'(locked), 0);
    repeat (2) send_good();
    settle();
    chk("relock_5_locked", int'(locked), 1);
    chk("relock_err_cnt", int'(err_cnt), 5);

    // All-zero word: sticky flag, then clear.
    avoid(5'b00000);
    drive(1'b1, 5'b00000, 1'b0); pos++;
    settle();
    chk("zero_set", int'(zero_err), 1);
    chk("zero_err_cnt", int'(err_cnt), 6);
    repeat (3) send_good();
    settle();
    chk("zero_sticky", int'(zero_err), 1);
    chk("zero_after_err_cnt", int'(err_cnt), 7);
    drive(1'b0, 5'b00000, 1'b1);
    settle();
    chk("clr_zero_err", int'(zero_err), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_locked", int'(locked), 1);

    // Clear coinciding with a new error: clear wins, pulse still fires.
    avoid(5'b01010);
    drive(1'b1, 5'b01010, 1'b1); pos++;
    settle();
    chk("clr_err_pulse", int'(err_pulse), 1);
    chk("clr_err_cnt_prio", int'(err_cnt), 0);
    send_good();
    settle();
    chk("post_clr_err_cnt", int'(err_cnt), 1);

    // Random en gaps over a correct stream.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 1) send_good();
      else drive(1'b0, 5'($urandom_range(0, 31)), 1'b0);
    end
    settle();
    chk("gaps_locked", int'(locked), 1);
    chk("gaps_err_cnt", int'(err_cnt), 1);

    // Arm the period monitor on a seed, then drop one word.
    while (pos % 31 != 0) send_good();
    send_good();
    settle();
    chk("armed_period_err", int'(period_err), 0);
    repeat (5) send_good();
    pos++;
    while (pos % 31 != 0) send_good();
    send_good();
    settle();
    chk("drop_period_err", int'(period_err), 1);
    chk("drop_err_cnt", int'(err_cnt), 2);
    chk("drop_locked", int'(locked), 1);

    // Asynchronous reset mid-lock.
    rst = 1'b1;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_err_pulse", int'(err_pulse), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_zero_err", int'(zero_err), 0);
    chk("arst_period_err", int'(period_err), 0);
    drive(1'b0, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_good();
    settle();
    chk("post_rst_capture_locked", int'(locked), 0);
    chk("post_rst_capture_pulse", int'(err_pulse), 0);
    repeat (3) send_good();
    settle();
    chk("post_rst_4_locked", int'(locked), 0);
    send_good();
    settle();
    chk("post_rst_5_locked", int'(locked), 1);
    chk("post_rst_err_cnt", int'(err_cnt), 0);

    drive(1'b0, 5'b00000, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
